// File: rtl/led_unstack_mode_pkg.sv
// Shared definitions for the LED mode generators: FSM state encoding and the
// default LED count.
package led_unstack_mode_pkg;

  localparam int unsigned LED_WIDTH = 8;

  typedef enum logic [1:0] {
    STACK = 2'd0,
    FALL  = 2'd1,
    EMPTY = 2'd2
  } mode_state_e;

endpackage

// File: rtl/mode_tick_div.sv
// Enable-gated prescaler: emits a one-cycle step strobe every TICK_DIV enabled
// cycles. The count freezes while en is low.
module mode_tick_div #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic step
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign step   = en && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/led_unstack_mode.sv
// Unstacking LED mode: starts all-on, releases the lowest stacked LED which
// falls bit by bit to bit 0, and wraps to all-on once the display is dark.
module led_unstack_mode
  import led_unstack_mode_pkg::*;
#(
  parameter int unsigned WIDTH    = LED_WIDTH,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  output logic [WIDTH-1:0]           OUT,
  output logic [$clog2(WIDTH+1)-1:0] stack_cnt,
  output logic                       done
);

  localparam int unsigned KW = $clog2(WIDTH + 1);
  localparam logic [KW-1:0]    K_FULL = KW'(WIDTH);
  localparam logic [KW-1:0]    ONE    = KW'(1);
  localparam logic [WIDTH-1:0] ALL1   = '1;
  localparam logic [WIDTH-1:0] BIT0   = WIDTH'(1);

  mode_state_e      r_state, w_state_d;
  logic [KW-1:0]    r_k, w_k_d;
  logic [KW-1:0]    r_p, w_p_d;
  logic [WIDTH-1:0] r_out, w_out_d;
  logic             r_done, w_done_d;
  logic [KW-1:0]    w_gap;
  logic             w_step;

  mode_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .step  (w_step)
  );

  // Position of the lowest stacked bit; zero means the stack fills the display.
  assign w_gap = K_FULL - r_k;

  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    w_p_d     = r_p;
    w_done_d  = 1'b0;
    if (w_step) begin
      unique case (r_state)
        STACK: begin
          if (r_k != '0) begin
            w_k_d = r_k - ONE;
            if (w_gap != '0) begin
              w_p_d     = w_gap - ONE;
              w_state_d = FALL;
            end
          end
        end
        FALL: begin
          if (r_p != '0) begin
            w_p_d = r_p - ONE;
          end else begin
            w_state_d = (r_k == '0) ? EMPTY : STACK;
          end
        end
        EMPTY: begin
          w_k_d     = K_FULL;
          w_state_d = STACK;
          w_done_d  = 1'b1;
        end
        default: w_state_d = STACK;
      endcase
    end
    // Stack mask is the top k bits; the mover is overlaid only while falling.
    w_out_d = ~(ALL1 >> w_k_d);
    if (w_state_d == FALL) begin
      w_out_d = w_out_d | (BIT0 << w_p_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STACK;
      r_k     <= K_FULL;
      r_p     <= '0;
      r_out   <= ALL1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
      r_p     <= w_p_d;
      r_out   <= w_out_d;
      r_done  <= w_done_d;
    end
  end

  assign OUT       = r_out;
  assign stack_cnt = r_k;
  assign done      = r_done;

endmodule

// File: tb/tb_led_unstack_mode.sv
// Directed bench for led_unstack_mode: full-period sequences for 8 and 4 LEDs,
// enable hold, prescaled stepping and asynchronous reset mid-fall.
module tb_led_unstack_mode;

  logic       clk = 1'b0;
  logic       rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic [7:0] out_a, out_b;
  logic [3:0] cnt_a, cnt_b;
  logic [3:0] out_c;
  logic [2:0] cnt_c;
  logic       done_a, done_b, done_c;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] seq8 [37];
  logic [7:0] seq4 [11];

  always #5 clk = ~clk;

  led_unstack_mode #(.WIDTH(8), .TICK_DIV(1)) u_dut_a (
    .clk (clk), .reset (rst_a), .en (en_a),
    .OUT (out_a), .stack_cnt (cnt_a), .done (done_a)
  );

  led_unstack_mode #(.WIDTH(8), .TICK_DIV(3)) u_dut_b (
    .clk (clk), .reset (rst_b), .en (en_b),
    .OUT (out_b), .stack_cnt (cnt_b), .done (done_b)
  );

  led_unstack_mode #(.WIDTH(4), .TICK_DIV(1)) u_dut_c (
    .clk (clk), .reset (rst_c), .en (en_c),
    .OUT (out_c), .stack_cnt (cnt_c), .done (done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stack height equals the run of ones from the MSB: the mover never touches the stack.
  function automatic logic [31:0] lead_ones(input logic [7:0] v, input int w);
    int n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (!v[i]) break;
      n++;
    end
    return n;
  endfunction

  initial begin
    int last_done;
    int n_done;
    int n_en;

    seq8 = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFA, 8'hF9, 8'hF8, 8'hF4, 8'hF2, 8'hF1,
             8'hF0, 8'hE8, 8'hE4, 8'hE2, 8'hE1, 8'hE0, 8'hD0, 8'hC8, 8'hC4, 8'hC2,
             8'hC1, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    seq4 = '{8'hF, 8'hE, 8'hD, 8'hC, 8'hA, 8'h9, 8'h8, 8'h4, 8'h2, 8'h1, 8'h0};

    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    rst_c = 1'b1; en_c = 1'b0;

    #12;
    chk("rst_out", 32'(out_a), 32'hFF);
    chk("rst_cnt", 32'(cnt_a), 32'd8);
    chk("rst_done", 32'(done_a), 32'd0);

    // Three back-to-back periods with every frame checked.
    @(negedge clk);
    rst_a = 1'b0;
    en_a  = 1'b1;
    last_done = 0;
    n_done    = 0;
    for (int i = 1; i <= 111; i++) begin
      @(negedge clk);
      chk("seq_out", 32'(out_a), 32'(seq8[i % 37]));
      chk("seq_cnt", 32'(cnt_a), lead_ones(seq8[i % 37], 8));
      chk("seq_done", 32'(done_a), 32'((i % 37) == 0));
      chk("seq_known", 32'($isunknown(out_a)), 32'd0);
      if (done_a === 1'b1) begin
        if (n_done > 0) chk("done_gap", 32'(i - last_done), 32'd37);
        last_done = i;
        n_done++;
      end
    end
    chk("done_count", 32'(n_done), 32'd3);

    // Walk to 88 (stack 80, mover at bit 3) and reset between clock edges.
    for (int i = 1; i <= 24; i++) @(negedge clk);
    chk("pre_rst_out", 32'(out_a), 32'h88);
    #2 rst_a = 1'b1;
    #1;
    chk("async_out", 32'(out_a), 32'hFF);
    chk("async_cnt", 32'(cnt_a), 32'd8);
    chk("async_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("restart_out", 32'(out_a), 32'hFE);
    chk("restart_done", 32'(done_a), 32'd0);

    // Hold at F4 with enable low, then resume.
    for (int i = 2; i <= 7; i++) @(negedge clk);
    chk("pre_hold_out", 32'(out_a), 32'hF4);
    en_a = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("hold_out", 32'(out_a), 32'hF4);
      chk("hold_cnt", 32'(cnt_a), 32'd4);
    end
    en_a = 1'b1;
    @(negedge clk);
    chk("resume_out", 32'(out_a), 32'hF2);
    en_a = 1'b0;

    // TICK_DIV=3 with enable toggling every cycle: one step per 3 enabled cycles.
    rst_b = 1'b0;
    n_en  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("div_out", 32'(out_b), 32'(seq8[n_en / 3]));
      en_b = ((c % 2) == 0);
      if (en_b) n_en++;
    end
    @(negedge clk);
    chk("div_final", 32'(out_b), 32'hFD);
    chk("div_cnt", 32'(cnt_b), 32'd6);
    chk("div_done", 32'(done_b), 32'd0);
    en_b = 1'b0;

    // Four LEDs: two full periods.
    rst_c = 1'b0;
    en_c  = 1'b1;
    n_done = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      chk("w4_out", 32'(out_c), 32'(seq4[i % 11]));
      chk("w4_cnt", 32'(cnt_c), lead_ones({seq4[i % 11][3:0], 4'h0}, 8));
      chk("w4_done", 32'(done_c), 32'((i % 11) == 0));
      if (done_c === 1'b1) n_done++;
    end
    chk("w4_done_count", 32'(n_done), 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
